// File: rtl/spi_master_driver_pkg.sv
// spi_master_driver_pkg: state encoding and default frame geometry for the SPI master.
package spi_master_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_HALFPERIOD = 16;
endpackage

// File: rtl/spi_master_driver_if.sv
// spi_master_driver_if: parallel request/response bus plus the four SPI wires.
interface spi_master_driver_if #(parameter int WIDTH = 16);
    logic start;
    logic [WIDTH-1:0] txdata;
    logic busy;
    logic done;
    logic [WIDTH-1:0] rxdata;
    logic cs;
    logic sclk;
    logic mosi;
    logic miso;
    modport master(input start, txdata, miso, output busy, done, rxdata, cs, sclk, mosi);
    modport slave(output start, txdata, miso, input busy, done, rxdata, cs, sclk, mosi);
endinterface

// File: rtl/spi_master_driver_sync.sv
// bit_synchronizer: two-flop synchroniser bringing asynchronous miso into clk.
module bit_synchronizer (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q <= 1'b0;
        end else begin
            meta <= d;
            q <= meta;
        end
    end
endmodule

// File: rtl/spi_master_driver.sv
// spi_master_driver: mode-0 SPI master, MSB first, every phase HALFPERIOD clk cycles.
module spi_master_driver
    import spi_master_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int HALFPERIOD = DEF_HALFPERIOD
) (
    input logic clk,
    input logic reset,
    spi_master_driver_if.master bus
);
    localparam int PW = $clog2(HALFPERIOD);
    localparam int CW = $clog2(WIDTH + 1);
    state_t state, nxt;
    logic [PW-1:0] ph;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] tx_sr, rx_sr;
    logic miso_s, last;
    bit_synchronizer u_sync (.clk(clk), .reset(reset), .d(bus.miso), .q(miso_s));
    assign last = ph == PW'(HALFPERIOD - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  nxt = bus.start ? SETUP : IDLE;
            SETUP: nxt = last ? LOW : SETUP;
            LOW:   nxt = last ? HIGH : LOW;
            HIGH:  nxt = last ? (cnt == '0 ? HOLD : LOW) : HIGH;
            HOLD:  nxt = last ? GAP : HOLD;
            GAP:   nxt = last ? IDLE : GAP;
            default: nxt = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they switch exactly with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph <= '0;
            cnt <= '0;
            tx_sr <= '0;
            rx_sr <= '0;
            bus.cs <= 1'b1;
            bus.sclk <= 1'b0;
            bus.mosi <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.rxdata <= '0;
        end else begin
            ph <= (state == IDLE || nxt != state) ? '0 : ph + 1'b1;
            bus.cs <= !(nxt inside {SETUP, LOW, HIGH, HOLD});
            bus.sclk <= nxt == HIGH;
            bus.busy <= nxt != IDLE;
            bus.done <= state == HOLD && last;
            if (state == IDLE && bus.start) begin
                tx_sr <= bus.txdata;
                bus.mosi <= bus.txdata[WIDTH-1];
                cnt <= CW'(WIDTH - 1);
            end
            // Sample miso at the very end of the high phase to absorb slave delay.
            if (state == HIGH && last) begin
                rx_sr <= {rx_sr[WIDTH-2:0], miso_s};
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                    tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
                    bus.mosi <= tx_sr[WIDTH-2];
                end
            end
            if (state == HOLD && last) bus.rxdata <= rx_sr;
        end
    end
endmodule
